// File: rtl/layer_seq_ctrl_pkg.sv
// Shared types and width helpers for the layer sequencing controller.
package layer_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClear,
        StRun,
        StHold,
        StErr
    } state_e;

    // Packed vector of n signed elements, each dw bits wide.
    function automatic int unsigned vec_width(input int unsigned n, input int unsigned dw);
        return n * dw;
    endfunction

    // Biases are double-width so they line up with the product accumulator.
    function automatic int unsigned bias_width(input int unsigned r, input int unsigned dw);
        return r * 2 * dw;
    endfunction

    // Each result row carries the product width plus growth for the column sum.
    function automatic int unsigned out_width(input int unsigned r, input int unsigned c,
                                              input int unsigned dw);
        return r * (2 * dw + $clog2(c));
    endfunction

    function automatic int unsigned sel_width(input int unsigned r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    localparam int unsigned VW = vec_width(3, 4);
    localparam int unsigned WW = vec_width(3, 4);
    localparam int unsigned BW = bias_width(4, 4);
    localparam int unsigned OW = out_width(4, 3, 4);

endpackage

// File: rtl/layer_seq_ctrl.sv
// Sequencer that loads weights/biases into a neural layer, runs one input
// vector through it and hands the registered result downstream.
module layer_seq_ctrl
    import layer_seq_ctrl_pkg::*;
#(
    parameter int unsigned rows        = 4,
    parameter int unsigned columns     = 3,
    parameter int unsigned max_rows    = 4,
    parameter int unsigned max_columns = 3,
    parameter int unsigned datawidth   = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                                          clk,
    input  logic                                          rst_overall,
    input  logic                                          cfg_start,
    input  logic [bias_width(max_rows, datawidth)-1:0]    cfg_bias,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [vec_width(max_columns, datawidth)-1:0]  cfg_weight,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [vec_width(columns, datawidth)-1:0]      in_values,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [out_width(rows, columns, datawidth)-1:0] out_data,
    output logic [vec_width(columns, datawidth)-1:0]      lyr_values,
    output logic [sel_width(max_rows)-1:0]                lyr_row_sel,
    output logic [vec_width(max_columns, datawidth)-1:0]  lyr_weight_update,
    output logic [bias_width(max_rows, datawidth)-1:0]    lyr_bias_updates,
    output logic                                          lyr_rst_vals,
    output logic                                          lyr_en,
    output logic                                          lyr_train_en,
    input  logic [out_width(rows, columns, datawidth)-1:0] lyr_out,
    input  logic                                          lyr_done,
    output logic                                          configured,
    output logic                                          busy,
    output logic                                          err
);

    localparam int unsigned vw    = vec_width(columns, datawidth);
    localparam int unsigned bw    = bias_width(max_rows, datawidth);
    localparam int unsigned ow    = out_width(rows, columns, datawidth);
    localparam int unsigned sel_w = sel_width(max_rows);
    localparam int unsigned cnt_w = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [sel_w-1:0]   row_cnt_q, row_cnt_d;
    logic [cnt_w-1:0]   run_cnt_q, run_cnt_d;
    logic               configured_q, configured_d;
    logic [vw-1:0]      values_q, values_d;
    logic [bw-1:0]      bias_q, bias_d;
    logic [ow-1:0]      out_q, out_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_overall) begin
            state_q      <= StIdle;
            row_cnt_q    <= '0;
            run_cnt_q    <= '0;
            configured_q <= 1'b0;
            values_q     <= '0;
            bias_q       <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            run_cnt_q    <= run_cnt_d;
            configured_q <= configured_d;
            values_q     <= values_d;
            bias_q       <= bias_d;
            out_q        <= out_d;
        end
    end

    // Next-state logic and per-state strobes; strobes are exclusive by state.
    always_comb begin
        state_d           = state_q;
        row_cnt_d         = row_cnt_q;
        run_cnt_d         = run_cnt_q;
        configured_d      = configured_q;
        values_d          = values_q;
        bias_d            = bias_q;
        out_d             = out_q;
        cfg_ready         = 1'b0;
        in_ready          = 1'b0;
        lyr_train_en      = 1'b0;
        lyr_en            = 1'b0;
        lyr_rst_vals      = 1'b0;
        lyr_weight_update = '0;
        unique case (state_q)
            StIdle: begin
                // cfg_start wins over a pending input
                in_ready = configured_q && !cfg_start;
                if (cfg_start) begin
                    bias_d       = cfg_bias;
                    configured_d = 1'b0;
                    row_cnt_d    = '0;
                    state_d      = StLoad;
                end else if (in_valid && configured_q) begin
                    values_d = in_values;
                    state_d  = StClear;
                end
            end
            StLoad: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    lyr_train_en      = 1'b1;
                    lyr_weight_update = cfg_weight;
                    row_cnt_d         = row_cnt_q + sel_w'(1);
                    if (row_cnt_q == sel_w'(rows - 1)) begin
                        configured_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            StClear: begin
                lyr_rst_vals = 1'b1;
                run_cnt_d    = '0;
                state_d      = StRun;
            end
            StRun: begin
                lyr_en = 1'b1;
                if (lyr_done) begin
                    out_d   = lyr_out;
                    state_d = StHold;
                end else if (run_cnt_q == cnt_w'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end else begin
                    run_cnt_d = run_cnt_q + cnt_w'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                // sticky until reset
                state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Status and registered data outputs decoded from state.
    always_comb begin
        out_valid        = (state_q == StHold);
        busy             = (state_q != StIdle);
        err              = (state_q == StErr);
        configured       = configured_q;
        out_data         = out_q;
        lyr_values       = values_q;
        lyr_bias_updates = bias_q;
        lyr_row_sel      = row_cnt_q;
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: a behavioural layer stub, a cycle-level
// transaction model checked every cycle, and directed literal checks.
`timescale 1ns/1ps
module tb_layer_seq_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int MROWS = 4;
    localparam int MCOLS = 3;
    localparam int DW    = 4;
    localparam int TMO   = 64;
    localparam int LAT   = 3;
    localparam int VWB   = COLS * DW;
    localparam int WWB   = MCOLS * DW;
    localparam int BWB   = MROWS * 2 * DW;
    localparam int RW    = 2 * DW + $clog2(COLS);
    localparam int OWB   = ROWS * RW;
    localparam int SELB  = $clog2(MROWS);

    typedef logic signed [DW-1:0] wmat_t [MROWS][MCOLS];

    logic            clk = 1'b0;
    logic            rst_overall, cfg_start, cfg_valid, cfg_ready;
    logic [BWB-1:0]  cfg_bias;
    logic [WWB-1:0]  cfg_weight;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [VWB-1:0]  in_values;
    logic [OWB-1:0]  out_data;
    logic [VWB-1:0]  lyr_values;
    logic [SELB-1:0] lyr_row_sel;
    logic [WWB-1:0]  lyr_weight_update;
    logic [BWB-1:0]  lyr_bias_updates;
    logic            lyr_rst_vals, lyr_en, lyr_train_en;
    logic [OWB-1:0]  lyr_out;
    logic            lyr_done;
    logic            configured, busy, err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_seq_ctrl #(
        .rows(ROWS), .columns(COLS), .max_rows(MROWS), .max_columns(MCOLS),
        .datawidth(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_overall(rst_overall), .cfg_start(cfg_start), .cfg_bias(cfg_bias),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_weight(cfg_weight),
        .in_valid(in_valid), .in_ready(in_ready), .in_values(in_values),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lyr_values(lyr_values), .lyr_row_sel(lyr_row_sel),
        .lyr_weight_update(lyr_weight_update), .lyr_bias_updates(lyr_bias_updates),
        .lyr_rst_vals(lyr_rst_vals), .lyr_en(lyr_en), .lyr_train_en(lyr_train_en),
        .lyr_out(lyr_out), .lyr_done(lyr_done),
        .configured(configured), .busy(busy), .err(err)
    );

    // Layer result: per row, bias plus dot product of weight row and inputs.
    function automatic logic [OWB-1:0] layer_math(input logic [VWB-1:0] v,
                                                  input logic [BWB-1:0] b, input wmat_t w);
        logic [OWB-1:0] r;
        int acc;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            acc = int'($signed(b[i*2*DW +: 2*DW]));
            for (int j = 0; j < COLS; j++) begin
                acc += int'($signed(v[j*DW +: DW])) * int'(w[i][j]);
            end
            r[i*RW +: RW] = acc[RW-1:0];
        end
        return r;
    endfunction

    function automatic logic [VWB-1:0] pack3(input int a, input int b, input int c);
        logic [VWB-1:0] r;
        r = '0;
        r[0 +: DW]    = a[DW-1:0];
        r[DW +: DW]   = b[DW-1:0];
        r[2*DW +: DW] = c[DW-1:0];
        return r;
    endfunction

    function automatic logic [BWB-1:0] pack_bias(input int b0, input int b1, input int b2,
                                                 input int b3);
        logic [BWB-1:0] r;
        r = {b3[2*DW-1:0], b2[2*DW-1:0], b1[2*DW-1:0], b0[2*DW-1:0]};
        return r;
    endfunction

    function automatic logic [OWB-1:0] pack_out(input int r0, input int r1, input int r2,
                                                input int r3);
        logic [OWB-1:0] r;
        r = {r3[RW-1:0], r2[RW-1:0], r1[RW-1:0], r0[RW-1:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
    endtask

    // Layer stub: stores weight rows, finishes LAT enabled cycles after a clear.
    wmat_t sw;
    int    st_cnt;
    logic  stub_stuck;
    always @(posedge clk) begin
        if (rst_overall) begin
            st_cnt   <= 0;
            lyr_done <= 1'b0;
            lyr_out  <= '0;
        end else begin
            if (lyr_rst_vals) begin
                st_cnt   <= 0;
                lyr_done <= 1'b0;
            end else if (lyr_en && !lyr_done && !stub_stuck) begin
                st_cnt <= st_cnt + 1;
                if (st_cnt == LAT - 1) begin
                    lyr_done <= 1'b1;
                    lyr_out  <= layer_math(lyr_values, lyr_bias_updates, sw);
                end
            end
            if (lyr_train_en) begin
                for (int j = 0; j < MCOLS; j++) begin
                    sw[lyr_row_sel][j] <= lyr_weight_update[j*DW +: DW];
                end
            end
        end
    end

    // Transaction model: tracks configuration progress and the cycle numbers of
    // accept/done events; expected outputs follow from cycle offsets.
    bit             m_live = 1'b0;
    bit             m_cfg, m_loading;
    int             m_beats, m_acc, m_done;
    logic [VWB-1:0] m_vals;
    logic [BWB-1:0] m_bias;
    logic [OWB-1:0] m_out;
    wmat_t          mw;

    always @(negedge clk) begin : model_cmp
        int c;
        bit idle, clr, run_en, fail, hold, excl;
        c      = cyc;
        clr    = m_acc >= 0 && c == m_acc + 1;
        run_en = m_acc >= 0 && m_done < 0 && c >= m_acc + 2 && c < m_acc + 2 + TMO;
        fail   = m_acc >= 0 && m_done < 0 && c >= m_acc + 2 + TMO;
        hold   = m_acc >= 0 && m_done >= 0;
        idle   = !m_loading && m_acc < 0;
        if (m_live) begin
            check("in_ready", in_ready, idle && m_cfg && !cfg_start);
            check("busy", busy, !idle);
            check("cfg_ready", cfg_ready, m_loading);
            check("lyr_train_en", lyr_train_en, m_loading && cfg_valid);
            if (m_loading && cfg_valid) begin
                check("lyr_row_sel", lyr_row_sel, m_beats);
                check("lyr_weight_update", lyr_weight_update, cfg_weight);
            end
            check("lyr_rst_vals", lyr_rst_vals, clr);
            check("lyr_en", lyr_en, run_en);
            check("out_valid", out_valid, hold);
            check("out_data", out_data, m_out);
            check("err", err, fail);
            check("configured", configured, m_cfg);
            check("lyr_values", lyr_values, m_vals);
            check("lyr_bias_updates", lyr_bias_updates, m_bias);
            excl = $countones({lyr_train_en, lyr_en, lyr_rst_vals}) <= 1;
            check("strobe_exclusive", excl, 1'b1);
        end
        if (rst_overall) begin
            m_live    = 1'b1;
            m_cfg     = 1'b0;
            m_loading = 1'b0;
            m_beats   = 0;
            m_acc     = -1;
            m_done    = -1;
            m_vals    = '0;
            m_bias    = '0;
            m_out     = '0;
        end else if (m_live) begin
            if (idle && cfg_start) begin
                m_loading = 1'b1;
                m_beats   = 0;
                m_cfg     = 1'b0;
                m_bias    = cfg_bias;
            end else if (idle && m_cfg && in_valid) begin
                m_acc  = c;
                m_done = -1;
                m_vals = in_values;
            end
            if (m_loading && cfg_valid) begin
                for (int j = 0; j < COLS; j++) mw[m_beats][j] = cfg_weight[j*DW +: DW];
                m_beats++;
                if (m_beats == ROWS) begin
                    m_loading = 1'b0;
                    m_cfg     = 1'b1;
                end
            end
            if (run_en && lyr_done) begin
                m_done = c;
                m_out  = layer_math(m_vals, m_bias, mw);
            end
            if (hold && out_ready) m_acc = -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int nbeats, input bit gap);
        int seen;
        seen      = 0;
        cfg_start = 1'b1;
        cfg_bias  = pack_bias(100, -20, 35, -12);
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i == 1) begin
                cfg_valid = 1'b0;
                @(negedge clk);
                if (lyr_train_en) seen++;
                check("gap_train_en", lyr_train_en, 1'b0);
                step();
            end
            cfg_valid  = 1'b1;
            cfg_weight = pack3(2, -1, 5);
            @(negedge clk);
            if (lyr_train_en) seen++;
            check("beat_row_sel", lyr_row_sel, i);
            step();
        end
        cfg_valid = 1'b0;
        check("train_cycles", seen, nbeats);
    endtask

    task automatic send(input logic [VWB-1:0] v, output int acc_cyc);
        bit got;
        got      = 1'b0;
        acc_cyc  = 0;
        in_valid = 1'b1;
        in_values = v;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
            end
            step();
        end
        in_valid = 1'b0;
        if (!got) fail_now("input_accept");
    endtask

    task automatic wait_flag(input string name, input int bound, input bit use_err,
                             output int at_cyc);
        bit got;
        got    = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < bound && !got; k++) begin
            @(negedge clk);
            if ((use_err ? err : out_valid) == 1'b1) begin
                got    = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!got) fail_now(name);
    endtask

    initial begin : stim
        int acc, vc;
        logic [OWB-1:0] held;
        rst_overall = 1'b1;
        cfg_start   = 1'b0;
        cfg_bias    = '0;
        cfg_valid   = 1'b0;
        cfg_weight  = '0;
        in_valid    = 1'b0;
        in_values   = '0;
        out_ready   = 1'b0;
        stub_stuck  = 1'b0;
        repeat (3) step();
        rst_overall = 1'b0;
        @(negedge clk);
        check("reset_configured", configured, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);

        // Input offered before any configuration is never taken.
        step();
        in_valid  = 1'b1;
        in_values = pack3(7, -3, 4);
        repeat (3) begin
            @(negedge clk);
            check("unconfigured_in_ready", in_ready, 1'b0);
            check("unconfigured_busy", busy, 1'b0);
            step();
        end
        in_valid = 1'b0;

        // Four weight beats with one idle gap, then configured.
        configure(4, 1'b1);
        @(negedge clk);
        check("configured_after_load", configured, 1'b1);
        step();

        // One inference with out_ready high; cfg_start pulsed while running.
        out_ready = 1'b1;
        send(pack3(7, -3, 4), acc);
        step();
        step();
        cfg_start = 1'b1;
        cfg_bias  = pack_bias(1, 2, 3, 4);
        step();
        cfg_start = 1'b0;
        wait_flag("out_valid_1", 40, 1'b0, vc);
        check("latency", vc - acc, 6);
        check("result_rows", out_data, pack_out(137, 17, 72, 25));
        check("bias_after_ignored_start", lyr_bias_updates, pack_bias(100, -20, 35, -12));
        check("configured_after_ignored_start", configured, 1'b1);
        step();

        // Backpressure: result must hold for 10 cycles while out_ready is low.
        out_ready = 1'b0;
        send(pack3(-8, 7, -1), acc);
        wait_flag("out_valid_2", 40, 1'b0, vc);
        held = out_data;
        check("held_rows", out_data, pack_out(72, -48, 7, -40));
        step();
        in_valid  = 1'b1;
        in_values = pack3(1, 1, 1);
        repeat (10) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_data", out_data, held);
            check("hold_in_ready", in_ready, 1'b0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_in_ready", in_ready, 1'b0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("post_handshake_in_ready", in_ready, 1'b1);
        step();

        // Layer that never finishes: timeout into a sticky error.
        stub_stuck = 1'b1;
        send(pack3(3, 3, 3), acc);
        wait_flag("err_timeout", 100, 1'b1, vc);
        check("timeout_cycles", vc - acc, 2 + TMO);
        step();
        cfg_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("err_lyr_en", lyr_en, 1'b0);
            check("err_sticky", err, 1'b1);
            step();
        end
        cfg_start = 1'b0;

        // Reset after two of four beats aborts the load.
        rst_overall = 1'b1;
        step();
        rst_overall = 1'b0;
        stub_stuck  = 1'b0;
        configure(2, 1'b0);
        rst_overall = 1'b1;
        cfg_valid   = 1'b1;
        step();
        rst_overall = 1'b0;
        @(negedge clk);
        check("abort_configured", configured, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_train_en", lyr_train_en, 1'b0);
        check("abort_row_sel", lyr_row_sel, '0);
        check("abort_weight_update", lyr_weight_update, '0);
        check("abort_bias", lyr_bias_updates, '0);
        check("abort_values", lyr_values, '0);
        check("abort_err", err, 1'b0);
        step();
        cfg_valid = 1'b0;

        // Reset in the middle of a run yields no result.
        configure(4, 1'b0);
        out_ready = 1'b1;
        send(pack3(5, 5, 5), acc);
        step();
        step();
        rst_overall = 1'b1;
        step();
        rst_overall = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("midrun_out_valid", out_valid, 1'b0);
            check("midrun_configured", configured, 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 Parameters SHALL be: rows 4, active neuron rows; columns 3, active inputs; max_rows 4, bias bus rows; max_columns 3, weight bus columns; datawidth 4, signed element width; TIMEOUT 64, maximum cycles in RUN.
REQ-002 Derived widths SHALL be: VW=columns*datawidth; WW=max_columns*datawidth; BW=max_rows*2*datawidth; OW=rows*(2*datawidth+$clog2(columns)).
REQ-003 The design SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock
- rst_overall  in  1  synchronous active-high reset
- cfg_start  in  1  pulse that begins a weight/bias load
- cfg_bias  in  BW  bias bus, captured on cfg_start
- cfg_valid/cfg_ready  in/out  1/1  weight-row beat handshake
- cfg_weight  in  WW  one weight row per beat
- in_valid/in_ready  in/out  1/1  input-vector handshake
- in_values  in  VW  input vector
- out_valid/out_ready  out/in  1/1  result handshake
- out_data  out  OW  registered layer result
- lyr_values  out  VW  to layer values
- lyr_row_sel  out  $clog2(max_rows)  to layer row_sel
- lyr_weight_update  out  WW  to layer weight_update
- lyr_bias_updates  out  BW  to layer bias_updates
- lyr_rst_vals, lyr_en, lyr_train_en  out  1 each  layer controls
- lyr_out  in  OW  layer out
- lyr_done  in  1  layer done
- configured, busy, err  out  1 each  status

Function
REQ-005 FSM states SHALL be IDLE, LOAD, CLEAR, RUN, HOLD, ERR, each encoded in a registered state variable.
REQ-006 IDLE + cfg_start SHALL latch cfg_bias into lyr_bias_updates, clear configured and row counter, and enter LOAD; cfg_start in any other state SHALL be ignored.
REQ-007 In LOAD, cfg_ready SHALL be 1. Each accepted beat SHALL drive lyr_train_en=1, lyr_row_sel=counter and lyr_weight_update=cfg_weight in the same cycle, then increment the counter.
REQ-008 On the beat with counter==rows-1, the FSM SHALL set configured=1 and return to IDLE; cycles with cfg_valid=0 SHALL hold the counter and keep lyr_train_en=0.
REQ-009 in_ready SHALL equal (state==IDLE && configured && !cfg_start); cfg_start SHALL have priority over in_valid.
REQ-010 An accepted input SHALL be registered into lyr_values, which holds until the next accept; the FSM SHALL then enter CLEAR.
REQ-011 CLEAR SHALL last exactly one cycle with lyr_rst_vals=1, then enter RUN.
REQ-012 In RUN, lyr_en SHALL be 1 until lyr_done is sampled high. At that point lyr_out SHALL be registered into out_data and the FSM SHALL enter HOLD; lyr_en SHALL be 0 in HOLD.
REQ-013 Latency: accept at cycle N, CLEAR at N+1, lyr_en first high at N+2, out_valid high the cycle after lyr_done is sampled.
REQ-014 In HOLD, out_valid=1 and out_data SHALL be stable until out_ready; on the handshake cycle the FSM SHALL return to IDLE, and a new input SHALL be acceptable no earlier than the following cycle.
REQ-015 A RUN cycle counter SHALL enter ERR if lyr_done has not been seen after TIMEOUT cycles. ERR SHALL hold err=1 with all lyr_* strobes 0 and SHALL be left only by reset.
REQ-016 busy SHALL be 1 in all states except IDLE.
REQ-017 lyr_train_en, lyr_en and lyr_rst_vals SHALL be mutually exclusive in every cycle.

Reset
REQ-018 rst_overall SHALL force state IDLE and set to 0: all counters, configured, err, busy, out_valid, out_data, lyr_values, lyr_bias_updates, lyr_weight_update, lyr_row_sel and all strobes.
REQ-019 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation, leave configured=0 and produce no out_valid.

Structure
REQ-020 A shared package SHALL hold the FSM state enum and the width functions/constants VW, WW, BW, OW.
REQ-021 The block SHALL instantiate no sub-module; layer SHALL be instantiated beside it, in the parent or the bench.

Verification
REQ-022 Config: rows=4, weights [2,-1,5], biases [100,-20,35,-12]. Expected: 4 lyr_train_en cycles with row_sel 0..3, then configured=1.
REQ-023 Input [7,-3,4] with out_ready=1. Expected: out_data rows = 137, 17, 72, 25 (dot product 37), and out_valid exactly 2 cycles + layer latency after accept.
REQ-024 Hold out_ready=0 for 10 cycles. Expected: out_valid and out_data stable, in_ready=0 throughout.
REQ-025 in_valid before configuration, and cfg_start pulsed during RUN. Expected: in_ready=0 before configuration, and the cfg_start pulse has no effect.
REQ-026 Stub lyr_done held low. Expected: err=1 after 64 RUN cycles, and lyr_en=0 afterwards.
REQ-027 rst_overall asserted mid-LOAD after 2 beats. Expected: configured=0 and all outputs at reset values the next cycle.
